muldiv_hilo: RTL and testbench
==============================

MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and HI/LO width; legal values are even and 8..64.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is a no-op.
REQ-006 a  input  WIDTH  rs operand (dividend or multiplicand; MTHI/MTLO source).
REQ-007 b  input  WIDTH  rt operand (divisor or multiplier).
REQ-008 flush  input  1  abort the in-flight operation (pipeline flush or exception).
REQ-009 busy  output  1  high while the iterative calculation runs; the decode stage stalls MFHI, MFLO and new mul/div ops on it.
REQ-010 done  output  1  one-cycle pulse; HI/LO already hold the result in that cycle.
REQ-011 div_zero  output  1  pulses with done when DIV or DIVU has b==0.
REQ-012 hi  output  WIDTH  HI register (registered output).
REQ-013 lo  output  WIDTH  LO register (registered output).

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIN; transitions are IDLE->CALC on an accepted mul/div, CALC->FIN after the last iteration, and FIN->IDLE unconditionally.
REQ-015 For MTHI/MTLO with start in IDLE, HI (or LO) SHALL load a at the next edge, with no busy and no done.
REQ-016 For MTHI/MTLO with start outside IDLE, the request SHALL be ignored.
REQ-017 An accepted mul/div at edge k SHALL hold busy high in cycles k+1..k+WIDTH and pulse done in cycle k+WIDTH+1; there is one radix-2 iteration per cycle.
REQ-018 Operands SHALL be latched at acceptance, so later changes on a and b have no effect.
REQ-019 MULT and MULTU SHALL load {hi,lo} with the full 2*WIDTH product, signed or unsigned respectively.
REQ-020 DIV and DIVU SHALL load lo with the quotient and hi with the remainder.
REQ-021 Signed DIV SHALL truncate toward zero; the remainder sign follows the dividend.
REQ-022 DIV of (-2^(WIDTH-1)) by -1 SHALL give lo=-2^(WIDTH-1) and hi=0, with no flag.
REQ-023 Divide by zero SHALL skip CALC: IDLE->FIN, with done and div_zero in cycle k+1 and HI/LO unchanged.
REQ-024 start while busy or in FIN SHALL be ignored, with no queuing.
REQ-025 flush SHALL return the FSM to IDLE at the next edge, drop busy, suppress done, and leave HI/LO at their pre-operation values.
REQ-026 flush and start in the same cycle SHALL ignore start.
REQ-027 flush SHALL have no effect in the FIN cycle, because the result is already committed.
REQ-028 HI/LO SHALL change only on MTHI/MTLO, on FIN entry, or on reset.

Reset
REQ-029 reset SHALL force IDLE immediately, regardless of the clock.
REQ-030 While reset is high, busy=0, done=0, div_zero=0, hi=0 and lo=0, and the operand and iteration registers are cleared.
REQ-031 Reset asserted mid-operation SHALL discard the operation; there is no done after release.

Configuration
REQ-032 Macro MULDIV_FAST_MUL_EN defined: MULT/MULTU SHALL compute the product in a single cycle, going IDLE->FIN with done at k+1 and busy never high; division is unchanged.
REQ-033 Macro MULDIV_FAST_MUL_EN undefined: MULT/MULTU SHALL use iterative shift-add with the REQ-017 timing, and no WIDTH x WIDTH multiplier is inferred.

Verification
REQ-034 WIDTH=32, MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done at k+33 (k+1 fast).
REQ-035 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy for 32 cycles; DIVU a=0x80000000, b=0x10 -> lo=0x08000000, hi=0.
REQ-036 DIVU b=0 after MTHI 0x1234 and MTLO 0x5678 -> done and div_zero at k+1; hi=0x1234, lo=0x5678.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-038 MULTU started, flush at k+10 -> busy=0 at k+11; no done; HI/LO unchanged; next start is accepted.
REQ-039 reset pulsed mid-DIV (async, between edges) -> outputs 0 immediately; a start while busy (cycle k+5) is ignored, with exactly one done.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// Request/response bundle between decode and the HI/LO multiply-divide unit.
// Drives operation requests and returns busy/done status plus HI/LO contents.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle MULT/MULTU path.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    muldiv_hilo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   dv_q, dv_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               mul_q, mul_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;

    // Signed ops work on magnitudes; signs are reapplied when the result commits.
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] ma, mb;

    assign sgn = ~bus.op[0];
    assign sa  = sgn & bus.a[WIDTH-1];
    assign sb  = sgn & bus.b[WIDTH-1];
    assign ma  = sa ? -bus.a : bus.a;
    assign mb  = sb ? -bus.b : bus.b;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sh;
    logic [WIDTH-1:0]   rem_new;
    logic               borrow;
    logic [2*WIDTH-1:0] p_mul, p_div, p_step, res;
    logic [WIDTH-1:0]   q_fin, r_fin;

    assign sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, {WIDTH{p_q[0]}} & dv_q};
    assign p_mul   = {sum, p_q[WIDTH-1:1]};

    assign sh      = p_q[2*WIDTH-1:WIDTH-1];
    assign borrow  = sh < {1'b0, dv_q};
    assign rem_new = sh[WIDTH-1:0] - dv_q;
    assign p_div   = borrow ? {sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                            : {rem_new, p_q[WIDTH-2:0], 1'b1};

    assign p_step  = mul_q ? p_mul : p_div;
    assign q_fin   = qneg_q ? -p_step[WIDTH-1:0] : p_step[WIDTH-1:0];
    assign r_fin   = rneg_q ? -p_step[2*WIDTH-1:WIDTH]
                            : p_step[2*WIDTH-1:WIDTH];
    assign res     = mul_q ? (qneg_q ? -p_step : p_step) : {r_fin, q_fin};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ea, eb, prod;

    assign ea   = {{WIDTH{sa}}, bus.a};
    assign eb   = {{WIDTH{sb}}, bus.b};
    assign prod = ea * eb;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        dv_d    = dv_q;
        mul_d   = mul_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        3'b000, 3'b001: begin
                            dz_d = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                            hi_d    = prod[2*WIDTH-1:WIDTH];
                            lo_d    = prod[WIDTH-1:0];
                            state_d = FIN;
`else
                            p_d     = {{WIDTH{1'b0}}, mb};
                            dv_d    = ma;
                            mul_d   = 1'b1;
                            qneg_d  = sa ^ sb;
                            cnt_d   = '0;
                            state_d = CALC;
`endif
                        end
                        3'b010, 3'b011: begin
                            if (bus.b == '0) begin
                                dz_d    = 1'b1;
                                state_d = FIN;
                            end else begin
                                dz_d    = 1'b0;
                                p_d     = {{WIDTH{1'b0}}, ma};
                                dv_d    = mb;
                                mul_d   = 1'b0;
                                qneg_d  = sa ^ sb;
                                rneg_d  = sa;
                                cnt_d   = '0;
                                state_d = CALC;
                            end
                        end
                        3'b100:  hi_d = bus.a;
                        3'b101:  lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    p_d   = p_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIN;
                        hi_d    = res[2*WIDTH-1:WIDTH];
                        lo_d    = res[WIDTH-1:0];
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            dv_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            dv_q    <= dv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_q   <= mul_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q == CALC);
    assign bus.done     = (state_q == FIN);
    assign bus.div_zero = (state_q == FIN) && dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized and directed bench for muldiv_hilo against a cycle-level
// behavioural reference that uses plain integer multiply/divide.
module tb_muldiv_hilo;
    localparam int W = 32;

`ifdef MULDIV_FAST_MUL_EN
    localparam int          MUL_LAT  = 1;
    localparam int          MUL_BUSY = 0;
    localparam logic [2:0]  FL_OP    = 3'd3;
`else
    localparam int          MUL_LAT  = W + 1;
    localparam int          MUL_BUSY = W;
    localparam logic [2:0]  FL_OP    = 3'd1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    muldiv_hilo_if #(.WIDTH(W)) bus ();

    muldiv_hilo #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference result {hi,lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin
                q = sa * sb;
                return q;
            end
            3'd1: return ua * ub;
            3'd2: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // Cycle-level model: remaining busy cycles, a done flag, and HI/LO
    int          m_cnt;
    logic        m_fin, m_dz;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
            m_dz  <= 1'b0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (m_fin) begin
            m_fin <= 1'b0;
        end else if (m_cnt > 0) begin
            if (bus.flush) begin
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_fin <= 1'b1;
                    m_dz  <= 1'b0;
                    m_hi  <= m_pend[63:32];
                    m_lo  <= m_pend[31:0];
                end
            end
        end else if (bus.start && !bus.flush) begin
            case (bus.op)
                3'd4: m_hi <= bus.a;
                3'd5: m_lo <= bus.a;
                3'd0, 3'd1: begin
`ifdef MULDIV_FAST_MUL_EN
                    m_fin <= 1'b1;
                    m_dz  <= 1'b0;
                    m_hi  <= ref_res(bus.op, bus.a, bus.b) >> 32;
                    m_lo  <= ref_res(bus.op, bus.a, bus.b) & 64'hFFFF_FFFF;
`else
                    m_pend <= ref_res(bus.op, bus.a, bus.b);
                    m_cnt  <= W;
`endif
                end
                3'd2, 3'd3: begin
                    if (bus.b == 0) begin
                        m_fin <= 1'b1;
                        m_dz  <= 1'b1;
                    end else begin
                        m_pend <= ref_res(bus.op, bus.a, bus.b);
                        m_cnt  <= W;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("busy", bus.busy, m_cnt > 0);
            chk("done", bus.done, m_fin);
            chk("div_zero", bus.div_zero, m_fin && m_dz);
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy,
                          output logic dz);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clock);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat   = 1;
        nbusy = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) nbusy++;
            @(negedge clock);
            lat++;
        end
        dz = bus.div_zero;
        if (!bus.done) begin
            n_chk++;
            n_bad++;
            $display("FAIL timeout %s: no done after %0d cycles, want done",
                     nm, lat);
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = v;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom % 8)
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    int   lat, nb, nd;
    logic dz;

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        #12;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_dz", bus.div_zero, 1'b0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        mt(3'd4, 32'h1234);
        mt(3'd5, 32'h5678);
        chk("mthi", bus.hi, 32'h1234);
        chk("mtlo", bus.lo, 32'h5678);

        run_op("divu0", 3'd3, 32'h55, 32'h0, lat, nb, dz);
        chk("divu0_lat", lat, 1);
        chk("divu0_dz", dz, 1'b1);
        chk("divu0_hi", bus.hi, 32'h1234);
        chk("divu0_lo", bus.lo, 32'h5678);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, lat, nb, dz);
        chk("mult_lat", lat, MUL_LAT);
        chk("mult_busy", nb, MUL_BUSY);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);

        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, lat, nb, dz);
        chk("div_lat", lat, W + 1);
        chk("div_busy", nb, W);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        chk("model_div_hi", m_hi, 32'hFFFF_FFFF);

        run_op("divu", 3'd3, 32'h8000_0000, 32'h10, lat, nb, dz);
        chk("divu_lo", bus.lo, 32'h0800_0000);
        chk("divu_hi", bus.hi, 32'h0);

        run_op("divov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, dz);
        chk("divov_lo", bus.lo, 32'h8000_0000);
        chk("divov_hi", bus.hi, 32'h0);
        chk("divov_dz", dz, 1'b0);

        // Flush during an iterative op
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = FL_OP;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h0000_0077;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) nd++;
        end
        chk("flush_no_done", nd, 0);
        chk("flush_hi", bus.hi, 32'h0);
        chk("flush_lo", bus.lo, 32'h8000_0000);
        run_op("after_flush", 3'd1, 32'h0001_0000, 32'h0001_0000,
               lat, nb, dz);
        chk("after_flush_lat", lat, MUL_LAT);
        chk("after_flush_hi", bus.hi, 32'h1);
        chk("after_flush_lo", bus.lo, 32'h0);

        // Start while busy is dropped
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 3'd3;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(negedge clock);
        bus.start = 1'b0;
        nd = 0;
        repeat (60) begin
            @(negedge clock);
            if (bus.done) nd++;
        end
        chk("busy_start_dones", nd, 1);
        chk("busy_start_lo", bus.lo, 32'd14);
        chk("busy_start_hi", bus.hi, 32'd2);

        // Asynchronous reset mid-divide
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) nd++;
        end
        chk("arst_no_done", nd, 0);

        // Random traffic checked cycle by cycle against the model
        repeat (4000) begin
            @(negedge clock);
            bus.start = ($urandom % 4) == 0;
            bus.op    = 3'($urandom % 8);
            bus.a     = rv();
            bus.b     = rv();
            bus.flush = ($urandom % 60) == 0;
        end
        @(negedge clock);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (50) @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
